// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: watches NS/EW lamp buses for illegal codes,
// conflicting greens, out-of-order phases and bad dwell times.
module traffic_light_monitor #(
  parameter int GREEN_CYC  = 300_000_000,
  parameter int YELLOW_CYC = 100_000_000,
  parameter int ALLRED_CYC = 100_000_000,
  parameter int TOL_CYC    = 1000,
  parameter int TMR_W      = 29
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic [2:0]  ns_light,
  input  logic [2:0]  ew_light,
  input  logic        clr_err,
  output logic [2:0]  phase,
  output logic        phase_valid,
  output logic        err_conflict,
  output logic        err_code,
  output logic        err_seq,
  output logic        err_timing,
  output logic        err_any,
  output logic [15:0] cycle_count
);

  typedef enum logic {SYNC, LOCK} state_t;

  localparam logic [5:0] RR = 6'b100_100;
  localparam logic [TMR_W-1:0] T_G = TMR_W'(GREEN_CYC);
  localparam logic [TMR_W-1:0] T_Y = TMR_W'(YELLOW_CYC);
  localparam logic [TMR_W-1:0] T_R = TMR_W'(ALLRED_CYC);
  localparam logic [TMR_W-1:0] T_T = TMR_W'(TOL_CYC);

  state_t            state, state_nx;
  logic [2:0]        ns_s, ew_s, ns_p, ew_p;
  logic [5:0]        cur;
  logic [TMR_W-1:0]  tmr, exp_d, lo, hi;
  logic [2:0]        succ, phase_nx;
  logic [15:0]       cnt_nx;
  logic              chg, rr_prev, bad_conf, bad_code;
  logic              set_seq, set_tim;

  function automatic logic [5:0] pat(input logic [2:0] p);
    case (p)
      3'd0:    pat = 6'b001_100;
      3'd1:    pat = 6'b010_100;
      3'd3:    pat = 6'b100_001;
      3'd4:    pat = 6'b100_010;
      default: pat = RR;
    endcase
  endfunction

  function automatic logic oh(input logic [2:0] x);
    oh = (x == 3'b001) || (x == 3'b010) || (x == 3'b100);
  endfunction

  always_comb begin
    cur      = {ns_s, ew_s};
    chg      = cur != {ns_p, ew_p};
    rr_prev  = {ns_p, ew_p} == RR;
    bad_conf = (ns_s != 3'b100) && (ew_s != 3'b100);
    bad_code = !oh(ns_s) || !oh(ew_s);
    succ     = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
    unique case (1'b1)
      (phase == 3'd0) || (phase == 3'd3): exp_d = T_G;
      (phase == 3'd1) || (phase == 3'd4): exp_d = T_Y;
      default:                            exp_d = T_R;
    endcase
    lo       = exp_d - T_T;
    hi       = exp_d + T_T;
    state_nx = state;
    phase_nx = phase;
    cnt_nx   = cycle_count;
    set_seq  = 1'b0;
    set_tim  = 1'b0;
    if (bad_conf || bad_code) begin
      state_nx = SYNC;
    end else if (state == SYNC) begin
      if (chg && rr_prev && cur == pat(3'd0)) begin
        state_nx = LOCK;
        phase_nx = 3'd0;
      end else if (chg && rr_prev && cur == pat(3'd3)) begin
        state_nx = LOCK;
        phase_nx = 3'd3;
      end
    end else if (chg) begin
      set_tim = (tmr < lo) || (tmr > hi);
      if (cur == pat(succ)) begin
        phase_nx = succ;
        if (phase == 3'd5) cnt_nx = cycle_count + 16'd1;
      end else begin
        set_seq  = 1'b1;
        state_nx = SYNC;
      end
    end else begin
      // overlong dwell fires once, on the first count past the window
      set_tim = tmr == hi + 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      ns_s         <= 3'b100;
      ew_s         <= 3'b100;
      ns_p         <= 3'b100;
      ew_p         <= 3'b100;
      tmr          <= '0;
      state        <= SYNC;
      phase        <= 3'd0;
      cycle_count  <= 16'd0;
      err_conflict <= 1'b0;
      err_code     <= 1'b0;
      err_seq      <= 1'b0;
      err_timing   <= 1'b0;
    end else begin
      ns_s         <= ns_light;
      ew_s         <= ew_light;
      ns_p         <= ns_s;
      ew_p         <= ew_s;
      tmr          <= chg ? TMR_W'(1) : (&tmr ? tmr : tmr + 1'b1);
      state        <= state_nx;
      phase        <= phase_nx;
      cycle_count  <= cnt_nx;
      err_conflict <= (err_conflict & ~clr_err) | bad_conf;
      err_code     <= (err_code & ~clr_err) | bad_code;
      err_seq      <= (err_seq & ~clr_err) | set_seq;
      err_timing   <= (err_timing & ~clr_err) | set_tim;
    end
  end

  assign phase_valid = state == LOCK;
  assign err_any     = err_conflict | err_code | err_seq | err_timing;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed vector table plus hand sequences
// for conflict, sequence, timing, code and reset corner cases.
module tb_traffic_light_monitor;

  logic        clk_50MHz = 1'b0;
  logic        reset;
  logic [2:0]  ns_light, ew_light;
  logic        clr_err;
  logic [2:0]  phase;
  logic        phase_valid;
  logic        err_conflict, err_code, err_seq, err_timing, err_any;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  traffic_light_monitor #(
    .GREEN_CYC(12), .YELLOW_CYC(4), .ALLRED_CYC(4),
    .TOL_CYC(1), .TMR_W(8)
  ) dut (
    .clk_50MHz(clk_50MHz), .reset(reset),
    .ns_light(ns_light), .ew_light(ew_light),
    .clr_err(clr_err), .phase(phase),
    .phase_valid(phase_valid),
    .err_conflict(err_conflict), .err_code(err_code),
    .err_seq(err_seq), .err_timing(err_timing),
    .err_any(err_any), .cycle_count(cycle_count)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  typedef struct {
    logic [2:0]  ns;
    logic [2:0]  ew;
    int          n;
    logic [2:0]  ph;
    logic        v;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ns, input logic [2:0] ew,
                       input int n, input logic clr);
    ns_light = ns;
    ew_light = ew;
    for (int i = 0; i < n; i++) begin
      clr_err = (i == 0) ? clr : 1'b0;
      @(posedge clk_50MHz);
      #1;
    end
    clr_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " phase"}, 32'(phase), 0);
    chk({tag, " valid"}, 32'(phase_valid), 0);
    chk({tag, " errs"}, 32'({err_conflict, err_code, err_seq,
                               err_timing, err_any}), 0);
    chk({tag, " cnt"}, 32'(cycle_count), 0);
  endtask

  initial begin
    tbl[0]  = '{R, R, 4, 3'd0, 1'b0, 16'd0};
    tbl[1]  = '{G, R, 12, 3'd0, 1'b1, 16'd0};
    tbl[2]  = '{Y, R, 4, 3'd1, 1'b1, 16'd0};
    tbl[3]  = '{R, R, 4, 3'd2, 1'b1, 16'd0};
    tbl[4]  = '{R, G, 12, 3'd3, 1'b1, 16'd0};
    tbl[5]  = '{R, Y, 4, 3'd4, 1'b1, 16'd0};
    tbl[6]  = '{R, R, 4, 3'd5, 1'b1, 16'd0};
    tbl[7]  = '{G, R, 12, 3'd0, 1'b1, 16'd1};
    tbl[8]  = '{Y, R, 4, 3'd1, 1'b1, 16'd1};
    tbl[9]  = '{R, R, 4, 3'd2, 1'b1, 16'd1};
    tbl[10] = '{R, G, 12, 3'd3, 1'b1, 16'd1};
    tbl[11] = '{R, Y, 4, 3'd4, 1'b1, 16'd1};
    tbl[12] = '{R, R, 4, 3'd5, 1'b1, 16'd1};
    tbl[13] = '{G, R, 12, 3'd0, 1'b1, 16'd2};

    reset = 1'b1;
    ns_light = R;
    ew_light = R;
    clr_err = 1'b0;
    repeat (2) @(posedge clk_50MHz);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // two legal cycles with exact dwells
    foreach (tbl[i]) begin
      drive(tbl[i].ns, tbl[i].ew, tbl[i].n, 1'b0);
      chk($sformatf("v%0d phase", i), 32'(phase), 32'(tbl[i].ph));
      chk($sformatf("v%0d valid", i), 32'(phase_valid), 32'(tbl[i].v));
      chk($sformatf("v%0d cnt", i), 32'(cycle_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d any", i), 32'(err_any), 0);
    end

    // overlong green without a change, flagged once
    drive(G, R, 1, 1'b0);
    chk("g13 timing", 32'(err_timing), 0);
    drive(G, R, 3, 1'b0);
    chk("g16 timing", 32'(err_timing), 1);
    chk("g16 phase", 32'(phase), 0);
    chk("g16 valid", 32'(phase_valid), 1);
    drive(G, R, 3, 1'b1);
    chk("g19 cleared", 32'(err_timing), 0);
    drive(Y, R, 4, 1'b0);
    chk("g19 change timing", 32'(err_timing), 1);
    chk("p1 phase", 32'(phase), 1);
    drive(R, R, 4, 1'b1);
    chk("p2 timing clr", 32'(err_timing), 0);
    chk("p2 phase", 32'(phase), 2);
    // short green, then 11 and 13 within tolerance
    drive(R, G, 10, 1'b0);
    drive(R, Y, 4, 1'b0);
    chk("g10 timing", 32'(err_timing), 1);
    chk("g10 phase", 32'(phase), 4);
    chk("g10 valid", 32'(phase_valid), 1);
    drive(R, R, 4, 1'b1);
    chk("p5 clr", 32'(err_any), 0);
    drive(G, R, 11, 1'b0);
    chk("g11 cnt", 32'(cycle_count), 3);
    drive(Y, R, 4, 1'b0);
    chk("g11 timing", 32'(err_timing), 0);
    drive(R, R, 4, 1'b0);
    drive(R, G, 13, 1'b0);
    drive(R, Y, 4, 1'b0);
    chk("g13 change timing", 32'(err_timing), 0);
    chk("g13 phase", 32'(phase), 4);

    // one-clock conflict during P0
    drive(R, R, 4, 1'b0);
    drive(G, R, 5, 1'b0);
    chk("pre conf cnt", 32'(cycle_count), 4);
    drive(G, G, 1, 1'b0);
    chk("conf edge1", 32'(err_conflict), 0);
    drive(G, R, 1, 1'b0);
    chk("conf edge2", 32'(err_conflict), 1);
    chk("conf valid", 32'(phase_valid), 0);
    chk("conf phase held", 32'(phase), 0);
    drive(G, R, 5, 1'b0);
    chk("conf sticky", 32'(err_conflict), 1);
    chk("conf no relock", 32'(phase_valid), 0);
    drive(G, R, 1, 1'b1);
    chk("conf clr", 32'(err_conflict), 0);

    // skipped yellow, then relock on red/red -> P3
    drive(R, R, 4, 1'b0);
    drive(G, R, 12, 1'b0);
    chk("seq lock", 32'(phase_valid), 1);
    drive(R, R, 4, 1'b0);
    chk("seq err", 32'(err_seq), 1);
    chk("seq valid", 32'(phase_valid), 0);
    chk("seq timing", 32'(err_timing), 0);
    drive(R, G, 12, 1'b0);
    chk("relock valid", 32'(phase_valid), 1);
    chk("relock phase", 32'(phase), 3);
    chk("relock seq sticky", 32'(err_seq), 1);
    drive(R, Y, 4, 1'b0);
    drive(R, R, 4, 1'b1);
    chk("seq clr any", 32'(err_any), 0);
    chk("seq p5", 32'(phase), 5);

    // non-one-hot code, then clr racing a new conflict
    drive(3'b011, R, 2, 1'b0);
    chk("code err", 32'(err_code), 1);
    chk("code any", 32'(err_any), 1);
    chk("code valid", 32'(phase_valid), 0);
    drive(G, G, 1, 1'b0);
    drive(G, G, 1, 1'b1);
    chk("clr vs conf", 32'(err_conflict), 1);
    chk("clr code", 32'(err_code), 0);
    drive(R, R, 2, 1'b0);
    drive(R, R, 1, 1'b1);
    chk("clr all", 32'(err_any), 0);

    // asynchronous reset during P3
    drive(R, G, 3, 1'b0);
    chk("p3 lock", 32'(phase), 3);
    chk("p3 valid", 32'(phase_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async rst");
    ns_light = G;
    ew_light = R;
    @(posedge clk_50MHz);
    #1;
    chk_all_zero("rst held");
    reset = 1'b0;
    drive(G, R, 4, 1'b0);
    chk("post rst phase", 32'(phase), 0);
    chk("post rst valid", 32'(phase_valid), 1);
    chk("post rst any", 32'(err_any), 0);
    chk("post rst cnt", 32'(cycle_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
